// File: rtl/conv_sram_arbiter_if.sv
// Requester-side bundle of conv_sram_arbiter: conv engine and ICB host read/write
// handshakes plus the engine burst lock. The master modport is the requester side.
interface conv_sram_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int RD_WIDTH   = 128,
  parameter int WR_WIDTH   = 64
);
  logic                  eng_rd_req;
  logic [ADDR_WIDTH-1:0] eng_rd_addr;
  logic                  eng_rd_gnt;
  logic                  eng_rd_vld;
  logic [RD_WIDTH-1:0]   eng_rd_data;
  logic                  host_rd_req;
  logic [ADDR_WIDTH-1:0] host_rd_addr;
  logic                  host_rd_gnt;
  logic                  host_rd_vld;
  logic [RD_WIDTH-1:0]   host_rd_data;
  logic                  eng_wr_req;
  logic [ADDR_WIDTH-1:0] eng_wr_addr;
  logic [WR_WIDTH-1:0]   eng_wr_data;
  logic                  eng_wr_gnt;
  logic                  host_wr_req;
  logic [ADDR_WIDTH-1:0] host_wr_addr;
  logic [WR_WIDTH-1:0]   host_wr_data;
  logic                  host_wr_gnt;
  logic                  eng_lock;

  modport master (
    output eng_rd_req, eng_rd_addr, host_rd_req, host_rd_addr,
           eng_wr_req, eng_wr_addr, eng_wr_data,
           host_wr_req, host_wr_addr, host_wr_data, eng_lock,
    input  eng_rd_gnt, eng_rd_vld, eng_rd_data, host_rd_gnt, host_rd_vld, host_rd_data,
           eng_wr_gnt, host_wr_gnt
  );

  modport slave (
    input  eng_rd_req, eng_rd_addr, host_rd_req, host_rd_addr,
           eng_wr_req, eng_wr_addr, eng_wr_data,
           host_wr_req, host_wr_addr, host_wr_data, eng_lock,
    output eng_rd_gnt, eng_rd_vld, eng_rd_data, host_rd_gnt, host_rd_vld, host_rd_data,
           eng_wr_gnt, host_wr_gnt
  );
endinterface

// File: rtl/conv_sram_arbiter.sv
// Shares the conv SRAM read and write ports between the conv engine and the ICB host:
// engine priority, host anti-starvation override, burst lock and read-after-write stall.
module conv_sram_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int RD_WIDTH   = 128,
  parameter int WR_WIDTH   = 64,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_sram_arbiter_if.slave    bus,
  output logic                  sram_re,
  output logic [ADDR_WIDTH-1:0] sram_addr_r,
  input  logic [RD_WIDTH-1:0]   sram_dout,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr_w,
  output logic [WR_WIDTH-1:0]   sram_din,
  output logic [15:0]           conflict_cnt
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]            wcnt_rd_r, wcnt_wr_r;
  logic                  tag_vld_r, tag_host_r;
  logic [RD_WIDTH-1:0]   eng_data_r, host_data_r;
  logic [15:0]           conflict_r;
  logic                  host_wr_sel_s, eng_wr_sel_s, host_wr_gnt_s, eng_wr_gnt_s;
  logic                  host_rd_sel_s, eng_rd_sel_s, host_rd_gnt_s, eng_rd_gnt_s;
  logic                  raw_s, eng_vld_s, host_vld_s, host_lost_s;
  logic [ADDR_WIDTH-1:0] rd_cand_addr_s;

  // Lock freezes the wait count; a grant or a dropped request clears it.
  function automatic logic [3:0] wcnt_next(input logic [3:0] cur, input logic req,
                                           input logic gnt, input logic lock);
    if (lock) begin
      return cur;
    end else if (!req || gnt) begin
      return 4'd0;
    end else if (cur == 4'd15) begin
      return cur;
    end else begin
      return cur + 4'd1;
    end
  endfunction

  // Per-port arbitration and SRAM strobes; the read winner stalls on a same-address write.
  always_comb begin
    host_wr_sel_s  = 1'b0;
    eng_wr_sel_s   = 1'b0;
    host_rd_sel_s  = 1'b0;
    eng_rd_sel_s   = 1'b0;
    rd_cand_addr_s = {ADDR_WIDTH{1'b0}};
    sram_addr_w    = {ADDR_WIDTH{1'b0}};
    sram_din       = {WR_WIDTH{1'b0}};

    host_wr_sel_s = bus.host_wr_req & ~bus.eng_lock & (~bus.eng_wr_req | (wcnt_wr_r >= MAX_WAIT_C));
    eng_wr_sel_s  = bus.eng_wr_req & ~host_wr_sel_s;
    host_wr_gnt_s = host_wr_sel_s & ~rst;
    eng_wr_gnt_s  = eng_wr_sel_s & ~rst;
    sram_we       = host_wr_gnt_s | eng_wr_gnt_s;
    if (host_wr_gnt_s) begin
      sram_addr_w = bus.host_wr_addr;
      sram_din    = bus.host_wr_data;
    end else if (eng_wr_gnt_s) begin
      sram_addr_w = bus.eng_wr_addr;
      sram_din    = bus.eng_wr_data;
    end else begin
      sram_addr_w = {ADDR_WIDTH{1'b0}};
      sram_din    = {WR_WIDTH{1'b0}};
    end

    host_rd_sel_s  = bus.host_rd_req & ~bus.eng_lock & (~bus.eng_rd_req | (wcnt_rd_r >= MAX_WAIT_C));
    eng_rd_sel_s   = bus.eng_rd_req & ~host_rd_sel_s;
    rd_cand_addr_s = host_rd_sel_s ? bus.host_rd_addr : bus.eng_rd_addr;
    raw_s          = sram_we & (rd_cand_addr_s == sram_addr_w);
    host_rd_gnt_s  = host_rd_sel_s & ~raw_s & ~rst;
    eng_rd_gnt_s   = eng_rd_sel_s & ~raw_s & ~rst;
    sram_re        = host_rd_gnt_s | eng_rd_gnt_s;
    sram_addr_r    = sram_re ? rd_cand_addr_s : {ADDR_WIDTH{1'b0}};
  end

  assign bus.eng_rd_gnt  = eng_rd_gnt_s;
  assign bus.host_rd_gnt = host_rd_gnt_s;
  assign bus.eng_wr_gnt  = eng_wr_gnt_s;
  assign bus.host_wr_gnt = host_wr_gnt_s;

  // Returning data passes straight through for the owner; the other side keeps its last word.
  assign eng_vld_s         = tag_vld_r & ~tag_host_r & ~rst;
  assign host_vld_s        = tag_vld_r & tag_host_r & ~rst;
  assign bus.eng_rd_vld    = eng_vld_s;
  assign bus.host_rd_vld   = host_vld_s;
  assign bus.eng_rd_data   = eng_vld_s ? sram_dout : eng_data_r;
  assign bus.host_rd_data  = host_vld_s ? sram_dout : host_data_r;
  assign host_lost_s       = (bus.host_rd_req & ~host_rd_gnt_s) | (bus.host_wr_req & ~host_wr_gnt_s);
  assign conflict_cnt      = conflict_r;

  // Wait counters, read return tag, held read data and the host-conflict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_rd_r   <= 4'd0;
      wcnt_wr_r   <= 4'd0;
      tag_vld_r   <= 1'b0;
      tag_host_r  <= 1'b0;
      eng_data_r  <= {RD_WIDTH{1'b0}};
      host_data_r <= {RD_WIDTH{1'b0}};
      conflict_r  <= 16'd0;
    end else begin
      wcnt_rd_r  <= wcnt_next(wcnt_rd_r, bus.host_rd_req, host_rd_gnt_s, bus.eng_lock);
      wcnt_wr_r  <= wcnt_next(wcnt_wr_r, bus.host_wr_req, host_wr_gnt_s, bus.eng_lock);
      tag_vld_r  <= eng_rd_gnt_s | host_rd_gnt_s;
      tag_host_r <= host_rd_gnt_s;
      if (eng_vld_s) begin
        eng_data_r <= sram_dout;
      end
      if (host_vld_s) begin
        host_data_r <= sram_dout;
      end
      if (host_lost_s && (conflict_r != 16'hFFFF)) begin
        conflict_r <= conflict_r + 16'd1;
      end
    end
  end

endmodule
